linear_proj_out_writer: RTL and testbench

Drains the Q/K/V bundles emitted by the linear projection stage into an output true-dual-port BRAM, one word per cycle. It sits directly downstream of the projection top, consuming its `out_valid` and `done` strobes. It captures each 12-slice by `TOTAL_INPUT_W`-row bundle into a holding register and serialises it onto a BRAM write port. Each (matrix, head) pair gets its own address region, so the attention stage can later read Q/K/V per head.

---
 rtl/linear_proj_out_writer_if.sv | 33 +++
 rtl/linear_proj_out_writer.sv | 169 ++++++++++++++++
 tb/tb_linear_proj_out_writer.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/linear_proj_out_writer_if.sv
// Bundle-in / BRAM-port-A-out bus of the Q/K/V projection output writer.
// master = projection side (drives bundles), slave = the writer itself.
interface linear_proj_out_writer_if #(
  parameter int OUT_KEYS       = 256,
  parameter int NUM_HEADS      = 4,
  parameter int TOTAL_INPUT_W  = 2,
  parameter int ADDR_WIDTH_OUT = 10
);
  logic                                                   in_valid;
  logic                                                   in_done;
  logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][OUT_KEYS-1:0]  in_q;
  logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][OUT_KEYS-1:0]  in_k;
  logic [NUM_HEADS-1:0][TOTAL_INPUT_W-1:0][OUT_KEYS-1:0]  in_v;
  logic                                                   in_ready;
  logic                                                   out_ena;
  logic                                                   out_wea;
  logic [ADDR_WIDTH_OUT-1:0]                              out_addra;
  logic [OUT_KEYS-1:0]                                    out_dina;
  logic                                                   busy;
  logic                                                   done;
  logic                                                   overflow;
  logic [15:0]                                            wr_count;

  modport master (
    output in_valid, in_done, in_q, in_k, in_v,
    input  in_ready, out_ena, out_wea, out_addra, out_dina, busy, done, overflow, wr_count
  );

  modport slave (
    input  in_valid, in_done, in_q, in_k, in_v,
    output in_ready, out_ena, out_wea, out_addra, out_dina, busy, done, overflow, wr_count
  );
endinterface

// File: rtl/linear_proj_out_writer.sv
// Serialises Q/K/V projection bundles into per-(matrix,head) BRAM regions, one word per cycle.
// Optional feature macro: LINPROJ_WR_STATS_EN enables the saturating wr_count write counter.
module linear_proj_out_writer #(
  parameter int OUT_KEYS       = 256,
  parameter int NUM_HEADS      = 4,
  parameter int TOTAL_INPUT_W  = 2,
  parameter int REGION_DEPTH   = 64,
  parameter int ADDR_WIDTH_OUT = 10
) (
  input logic                     clk,
  input logic                     rst_n,
  linear_proj_out_writer_if.slave bus
);

  localparam int N      = 3 * NUM_HEADS * TOTAL_INPUT_W;
  localparam int TILES  = REGION_DEPTH / TOTAL_INPUT_W;
  localparam int IDX_W  = $clog2(N + 1);
  localparam int TILE_W = (TILES > 1) ? $clog2(TILES) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t                         state_r;
  logic [N-1:0][OUT_KEYS-1:0]     hold_r;
  logic [IDX_W-1:0]               idx_r;
  logic                           last_r;
  logic [TILE_W-1:0]              tile_r;
  logic                           pend_r;
  logic                           out_ena_r;
  logic [ADDR_WIDTH_OUT-1:0]      out_addra_r;
  logic [OUT_KEYS-1:0]            out_dina_r;
  logic                           done_r;
  logic                           overflow_r;

  logic                           in_ready_s;
  logic                           accept_s;
  logic [TILE_W-1:0]              tile_nxt_s;
  logic [TILE_W-1:0]              start_tile_s;

  // Word index runs matrix-major then head then row, so idx/TOTAL_INPUT_W is the region number.
  function automatic logic [ADDR_WIDTH_OUT-1:0] addr_of(input logic [IDX_W-1:0] idx,
                                                        input logic [TILE_W-1:0] tile);
    int unsigned i_u;
    int unsigned t_u;
    int unsigned a_u;
    i_u = 32'(idx);
    t_u = 32'(tile);
    a_u = (i_u / TOTAL_INPUT_W) * REGION_DEPTH + t_u * TOTAL_INPUT_W + (i_u % TOTAL_INPUT_W);
    return a_u[ADDR_WIDTH_OUT-1:0];
  endfunction

  assign in_ready_s   = (state_r == ST_IDLE) || ((state_r == ST_WRITE) && last_r);
  assign accept_s     = bus.in_valid && in_ready_s;
  assign tile_nxt_s   = (tile_r == TILE_W'(TILES - 1)) ? TILE_W'(0) : tile_r + TILE_W'(1);
  assign start_tile_s = (state_r == ST_IDLE) ? tile_r : tile_nxt_s;

  // Control FSM with registered BRAM port, busy, done and overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      hold_r      <= '0;
      idx_r       <= IDX_W'(0);
      last_r      <= 1'b0;
      tile_r      <= TILE_W'(0);
      pend_r      <= 1'b0;
      out_ena_r   <= 1'b0;
      out_addra_r <= ADDR_WIDTH_OUT'(0);
      out_dina_r  <= OUT_KEYS'(0);
      done_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.in_valid && !in_ready_s) begin
        overflow_r <= 1'b1;
      end
      if (accept_s) begin
        // Word 0 comes straight from the inputs so a chained bundle follows without a bubble.
        state_r     <= ST_WRITE;
        hold_r      <= {bus.in_v, bus.in_k, bus.in_q};
        tile_r      <= start_tile_s;
        idx_r       <= IDX_W'(1);
        last_r      <= (N == 1);
        out_ena_r   <= 1'b1;
        out_addra_r <= addr_of(IDX_W'(0), start_tile_s);
        out_dina_r  <= bus.in_q[0][0];
        if (bus.in_done) begin
          pend_r <= 1'b1;
        end
      end else begin
        case (state_r)
          ST_IDLE: begin
            out_ena_r <= 1'b0;
            if (bus.in_done) begin
              state_r <= ST_FLUSH;
              done_r  <= 1'b1;
              tile_r  <= TILE_W'(0);
            end
          end
          ST_WRITE: begin
            if (!last_r) begin
              out_ena_r   <= 1'b1;
              out_addra_r <= addr_of(idx_r, tile_r);
              out_dina_r  <= hold_r[idx_r];
              last_r      <= (idx_r == IDX_W'(N - 1));
              idx_r       <= idx_r + IDX_W'(1);
              if (bus.in_done) begin
                pend_r <= 1'b1;
              end
            end else begin
              out_ena_r <= 1'b0;
              last_r    <= 1'b0;
              if (pend_r || bus.in_done) begin
                state_r <= ST_FLUSH;
                done_r  <= 1'b1;
                pend_r  <= 1'b0;
                tile_r  <= TILE_W'(0);
              end else begin
                state_r <= ST_IDLE;
                tile_r  <= tile_nxt_s;
              end
            end
          end
          ST_FLUSH: begin
            out_ena_r <= 1'b0;
            pend_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
          default: begin
            out_ena_r <= 1'b0;
            last_r    <= 1'b0;
            state_r   <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_ena   = out_ena_r;
  assign bus.out_wea   = out_ena_r;
  assign bus.busy      = out_ena_r;
  assign bus.out_addra = out_addra_r;
  assign bus.out_dina  = out_dina_r;
  assign bus.done      = done_r;
  assign bus.overflow  = overflow_r;

`ifdef LINPROJ_WR_STATS_EN
  logic [15:0] wr_count_r;

  // Saturating count of BRAM write cycles; survives done, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_r <= 16'd0;
    end else if (out_ena_r && (wr_count_r != 16'hFFFF)) begin
      wr_count_r <= wr_count_r + 16'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign bus.wr_count = wr_count_r;
`else
  assign bus.wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_linear_proj_out_writer.sv
// Randomised bench for linear_proj_out_writer against a queue-based reference model.
// Honours LINPROJ_WR_STATS_EN for the expected wr_count.
module tb_linear_proj_out_writer;

  localparam int OUT_KEYS       = 256;
  localparam int NUM_HEADS      = 4;
  localparam int TOTAL_INPUT_W  = 2;
  localparam int REGION_DEPTH   = 64;
  localparam int ADDR_WIDTH_OUT = 10;
  localparam int TILES          = REGION_DEPTH / TOTAL_INPUT_W;

  typedef struct {
    logic [ADDR_WIDTH_OUT-1:0] addr;
    logic [OUT_KEYS-1:0]       data;
  } wr_t;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  linear_proj_out_writer_if #(
    .OUT_KEYS(OUT_KEYS), .NUM_HEADS(NUM_HEADS),
    .TOTAL_INPUT_W(TOTAL_INPUT_W), .ADDR_WIDTH_OUT(ADDR_WIDTH_OUT)
  ) bus ();

  linear_proj_out_writer #(
    .OUT_KEYS(OUT_KEYS), .NUM_HEADS(NUM_HEADS), .TOTAL_INPUT_W(TOTAL_INPUT_W),
    .REGION_DEPTH(REGION_DEPTH), .ADDR_WIDTH_OUT(ADDR_WIDTH_OUT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: words still to appear, the word on the port now, and job flags.
  wr_t         exp_q[$];
  wr_t         pres_m;
  logic        pres_valid_m;
  logic        done_m;
  logic        ovf_m;
  logic        pending_m;
  int          tile_m;
  logic [15:0] wr_m;

  task automatic chk(input string tag, input logic [OUT_KEYS-1:0] act, input logic [OUT_KEYS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    pres_valid_m = 1'b0;
    done_m       = 1'b0;
    ovf_m        = 1'b0;
    pending_m    = 1'b0;
    tile_m       = 0;
    wr_m         = 16'd0;
  endtask

  task automatic push_bundle();
    wr_t w;
    for (int mat = 0; mat < 3; mat++) begin
      for (int h = 0; h < NUM_HEADS; h++) begin
        for (int r = 0; r < TOTAL_INPUT_W; r++) begin
          w.addr = ADDR_WIDTH_OUT'((mat * NUM_HEADS + h) * REGION_DEPTH + tile_m * TOTAL_INPUT_W + r);
          w.data = (mat == 0) ? bus.in_q[h][r] : ((mat == 1) ? bus.in_k[h][r] : bus.in_v[h][r]);
          exp_q.push_back(w);
        end
      end
    end
  endtask

  task automatic model_step(input logic v, input logic d);
    logic ready;
    logic completing;
    ready      = !done_m && (exp_q.size() == 0);
    completing = pres_valid_m && (exp_q.size() == 0);
    if (v && !ready) ovf_m = 1'b1;
    if (pres_valid_m && wr_m != 16'hFFFF) wr_m = wr_m + 16'd1;
    if (completing) tile_m = (tile_m + 1) % TILES;
    if (v && ready) begin
      push_bundle();
      pres_m       = exp_q.pop_front();
      pres_valid_m = 1'b1;
      done_m       = 1'b0;
      if (d) pending_m = 1'b1;
    end else if (pres_valid_m && !completing) begin
      pres_m = exp_q.pop_front();
      done_m = 1'b0;
      if (d) pending_m = 1'b1;
    end else if (completing) begin
      pres_valid_m = 1'b0;
      done_m       = pending_m || d;
      if (pending_m || d) tile_m = 0;
      pending_m    = 1'b0;
    end else if (done_m) begin
      done_m    = 1'b0;
      pending_m = 1'b0;
    end else begin
      done_m = d;
      if (d) tile_m = 0;
    end
  endtask

  task automatic check_outputs();
    logic [15:0] wr_exp;
`ifdef LINPROJ_WR_STATS_EN
    wr_exp = wr_m;
`else
    wr_exp = 16'd0;
`endif
    chk("out_ena",  OUT_KEYS'(bus.out_ena),  OUT_KEYS'(pres_valid_m));
    chk("out_wea",  OUT_KEYS'(bus.out_wea),  OUT_KEYS'(pres_valid_m));
    chk("busy",     OUT_KEYS'(bus.busy),     OUT_KEYS'(pres_valid_m));
    chk("done",     OUT_KEYS'(bus.done),     OUT_KEYS'(done_m));
    chk("overflow", OUT_KEYS'(bus.overflow), OUT_KEYS'(ovf_m));
    chk("in_ready", OUT_KEYS'(bus.in_ready), OUT_KEYS'(!done_m && (exp_q.size() == 0)));
    chk("wr_count", OUT_KEYS'(bus.wr_count), OUT_KEYS'(wr_exp));
    if (pres_valid_m) begin
      chk("out_addra", OUT_KEYS'(bus.out_addra), OUT_KEYS'(pres_m.addr));
      chk("out_dina",  bus.out_dina,             pres_m.data);
    end
  endtask

  task automatic randomize_bundle();
    for (int h = 0; h < NUM_HEADS; h++) begin
      for (int r = 0; r < TOTAL_INPUT_W; r++) begin
        for (int w = 0; w < OUT_KEYS / 32; w++) begin
          bus.in_q[h][r][w*32 +: 32] = $urandom;
          bus.in_k[h][r][w*32 +: 32] = $urandom;
          bus.in_v[h][r][w*32 +: 32] = $urandom;
        end
      end
    end
  endtask

  // One clock: drive at negedge, step the model at posedge, check at the next negedge.
  task automatic cycle(input logic v, input logic d);
    bus.in_valid = v;
    bus.in_done  = d;
    randomize_bundle();
    @(posedge clk);
    model_step(v, d);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ena"},      OUT_KEYS'(bus.out_ena),   OUT_KEYS'(0));
    chk({tag, "_wea"},      OUT_KEYS'(bus.out_wea),   OUT_KEYS'(0));
    chk({tag, "_addra"},    OUT_KEYS'(bus.out_addra), OUT_KEYS'(0));
    chk({tag, "_dina"},     bus.out_dina,             OUT_KEYS'(0));
    chk({tag, "_busy"},     OUT_KEYS'(bus.busy),      OUT_KEYS'(0));
    chk({tag, "_done"},     OUT_KEYS'(bus.done),      OUT_KEYS'(0));
    chk({tag, "_overflow"}, OUT_KEYS'(bus.overflow),  OUT_KEYS'(0));
    chk({tag, "_wr_count"}, OUT_KEYS'(bus.wr_count),  OUT_KEYS'(0));
    chk({tag, "_in_ready"}, OUT_KEYS'(bus.in_ready),  OUT_KEYS'(1));
  endtask

  initial begin
    n_vec        = 0;
    n_err        = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_done  = 1'b0;
    bus.in_q     = '0;
    bus.in_k     = '0;
    bus.in_v     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Single bundle, then idle.
    cycle(1'b1, 1'b0);
    repeat (30) cycle(1'b0, 1'b0);

    // Back-to-back: second bundle presented on the last write cycle.
    cycle(1'b1, 1'b0);
    repeat (23) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (30) cycle(1'b0, 1'b0);

    // Bundle offered mid-write is dropped and sets overflow.
    cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    repeat (30) cycle(1'b0, 1'b0);

    // in_done during the bundle: done follows the 24th write, tile resets.
    cycle(1'b1, 1'b0);
    repeat (9) cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    repeat (20) cycle(1'b0, 1'b0);

    // 33 chained bundles: the last wraps to tile 0.
    for (int b = 0; b < 33; b++) begin
      cycle(1'b1, 1'b0);
      repeat (23) cycle(1'b0, 1'b0);
    end
    repeat (5) cycle(1'b0, 1'b0);

    // Idle in_done, and in_done together with a bundle.
    cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b1);
    repeat (30) cycle(1'b0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      cycle(($urandom_range(0, 9) == 0), ($urandom_range(0, 39) == 0));
    end
    repeat (30) cycle(1'b0, 1'b0);

    // Asynchronous reset at write 12, then a fresh bundle must start at address 0.
    cycle(1'b1, 1'b0);
    repeat (11) cycle(1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cycle(1'b1, 1'b0);
    chk("restart_addr", OUT_KEYS'(bus.out_addra), OUT_KEYS'(0));
    repeat (30) cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
